// File: rtl/pipelined_processor_pkg.sv
// rtl/pipelined_processor_pkg.sv - opcodes, memory sizes and pipeline-register types
// Shared by the core top and its ALU.
package pipelined_processor_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_SETC = 5'b00001;
  localparam logic [4:0] OP_NOT  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b11001;
  localparam logic [4:0] OP_STD  = 5'b01100;
  localparam logic [4:0] OP_LDD  = 5'b00100;
  localparam logic [4:0] OP_JMP  = 5'b10010;

  localparam logic [15:0] RESET_PC = 16'h0020;
  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [4:0] pad;
  } instr_t;

  typedef struct packed {
    instr_t instr;
  } if_id_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] va;
    logic [15:0] vb;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]  op;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] res;
    logic [15:0] sdata;
    logic [7:0]  maddr;
  } ex_mem_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
  } mem_wb_t;

  // Unknown opcodes are squashed to NOP at decode so later stages see only legal ops.
  function automatic logic [4:0] decode_op(input logic [4:0] op);
    case (op)
      OP_SETC, OP_NOT, OP_ADD, OP_STD, OP_LDD, OP_JMP: return op;
      default: return OP_NOP;
    endcase
  endfunction

  function automatic logic uses_a(input logic [4:0] op);
    return (op == OP_NOT) || (op == OP_ADD) || (op == OP_STD) || (op == OP_JMP);
  endfunction

  function automatic logic uses_b(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_STD) || (op == OP_LDD);
  endfunction

endpackage

// File: rtl/pp_alu.sv
// rtl/pp_alu.sv - combinational ADD/NOT/SETC with next {C,N,Z} flags
// Flags not touched by the opcode pass through unchanged.
module pp_alu
  import pipelined_processor_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [2:0]  flags_i,
  output logic [15:0] y_o,
  output logic [2:0]  flags_o
);
  logic [16:0] sum;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    y_o     = '0;
    flags_o = flags_i;
    case (op_i)
      OP_SETC: flags_o[2] = 1'b1;
      OP_NOT: begin
        y_o        = ~a_i;
        flags_o[1] = ~a_i[15];
        flags_o[0] = (a_i == 16'hFFFF);
      end
      OP_ADD: begin
        y_o     = sum[15:0];
        flags_o = {sum[16], sum[15], (sum[15:0] == 16'h0000)};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipelined_processor.sv
// rtl/pipelined_processor.sv - five-stage 16-bit core with loader port and debug outputs
// Define FORWARDING_EN for EX operand forwarding and the load-use stall.
module pipelined_processor
  import pipelined_processor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  write_addr,
  output logic [15:0] result,
  input  logic        write_enable_fm,
  input  logic        rst_fm,
  input  logic [15:0] write_data_fm,
  input  logic [31:0] write_addr_fm,
  output logic [15:0] instruction,
  output logic        mem_write,
  output logic [15:0] show
);
  logic [15:0] imem_q [IMEM_DEPTH];
  logic [15:0] dmem_q [DMEM_DEPTH];
  logic [15:0] regs_q [8];
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [4:0]  id_op;
  logic        stall, flush;
  logic [15:0] ex_a, ex_b, alu_y;
  logic        unused_fm_addr;

  assign unused_fm_addr = ^write_addr_fm[31:8];

  // Loader port runs regardless of the core reset; the clear beats a write.
  always_ff @(posedge clk) begin
    if (!rst_fm) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem_q[i[7:0]] <= '0;
    end else if (write_enable_fm) begin
      imem_q[write_addr_fm[7:0]] <= write_data_fm;
    end
  end

  always_comb begin
    id_op = decode_op(if_id_q.instr.op);
    flush = (id_ex_q.op == OP_JMP);
`ifdef FORWARDING_EN
    stall = (id_ex_q.op == OP_LDD) &&
            ((uses_a(id_op) && (if_id_q.instr.ra == id_ex_q.ra)) ||
             (uses_b(id_op) && (if_id_q.instr.rb == id_ex_q.ra)));
`else
    stall = 1'b0;
`endif
    id_ex_d = '0;
    if (!flush && !stall) begin
      id_ex_d.op = id_op;
      id_ex_d.ra = if_id_q.instr.ra;
      id_ex_d.rb = if_id_q.instr.rb;
      id_ex_d.va = (mem_wb_q.we && (mem_wb_q.wa == if_id_q.instr.ra)) ? mem_wb_q.wd
                                                                       : regs_q[if_id_q.instr.ra];
      id_ex_d.vb = (mem_wb_q.we && (mem_wb_q.wa == if_id_q.instr.rb)) ? mem_wb_q.wd
                                                                       : regs_q[if_id_q.instr.rb];
    end
  end

  always_comb begin
    ex_a = id_ex_q.va;
    ex_b = id_ex_q.vb;
`ifdef FORWARDING_EN
    // EX/MEM is newer than MEM/WB, so it is applied last; a load in MEM is never forwarded.
    if (mem_wb_q.we && (mem_wb_q.wa == id_ex_q.ra)) ex_a = mem_wb_q.wd;
    if (mem_wb_q.we && (mem_wb_q.wa == id_ex_q.rb)) ex_b = mem_wb_q.wd;
    if (ex_mem_q.we && (ex_mem_q.op != OP_LDD) && (ex_mem_q.wa == id_ex_q.ra)) ex_a = ex_mem_q.res;
    if (ex_mem_q.we && (ex_mem_q.op != OP_LDD) && (ex_mem_q.wa == id_ex_q.rb)) ex_b = ex_mem_q.res;
`endif
  end

  pp_alu u_alu (
    .op_i    (id_ex_q.op),
    .a_i     (ex_a),
    .b_i     (ex_b),
    .flags_i (flags_q),
    .y_o     (alu_y),
    .flags_o (flags_d)
  );

  always_comb begin
    ex_mem_d       = '0;
    ex_mem_d.op    = id_ex_q.op;
    ex_mem_d.we    = (id_ex_q.op == OP_NOT) || (id_ex_q.op == OP_ADD) || (id_ex_q.op == OP_LDD);
    ex_mem_d.wa    = (id_ex_q.op == OP_ADD) ? id_ex_q.rb : id_ex_q.ra;
    ex_mem_d.res   = alu_y;
    ex_mem_d.sdata = ex_a;
    ex_mem_d.maddr = ex_b[7:0];
  end

  assign mem_write = (ex_mem_q.op == OP_STD);

  always_comb begin
    mem_wb_d    = '0;
    mem_wb_d.we = ex_mem_q.we;
    mem_wb_d.wa = ex_mem_q.wa;
    mem_wb_d.wd = (ex_mem_q.op == OP_LDD) ? dmem_q[ex_mem_q.maddr] : ex_mem_q.res;
  end

  // A taken jump outranks a load-use hold.
  always_comb begin
    pc_d    = pc_q + 16'd1;
    if_id_d = '0;
    if (flush) begin
      pc_d = ex_a;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
    end else begin
      if_id_d.instr = imem_q[pc_q[7:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      flags_q  <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs_q[i[2:0]] <= 16'(i);
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i[7:0]] <= '0;
    end else begin
      if (mem_wb_q.we) regs_q[mem_wb_q.wa] <= mem_wb_q.wd;
      if (mem_write) dmem_q[ex_mem_q.maddr] <= ex_mem_q.sdata;
    end
  end

  assign result      = regs_q[write_addr];
  assign instruction = if_id_q.instr;
  assign show        = {13'b0, flags_q};

endmodule

// File: tb/tb_pipelined_processor.sv
// tb/tb_pipelined_processor.sv - directed and random programs against an ISA-level model
// Expectations follow FORWARDING_EN when the bench is built with it.
module tb_pipelined_processor;
  localparam logic [4:0] M_NOP = 5'b00000, M_SETC = 5'b00001, M_NOT = 5'b00011;
  localparam logic [4:0] M_ADD = 5'b11001, M_STD = 5'b01100, M_LDD = 5'b00100, M_JMP = 5'b10010;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rst_fm, write_enable_fm;
  logic [2:0]  write_addr;
  logic [15:0] write_data_fm;
  logic [31:0] write_addr_fm;
  logic [15:0] result, instruction, show;
  logic        mem_write;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] img [256];
  logic [15:0] mr  [8];
  logic [15:0] mdm [256];
  logic [2:0]  mf;
  int          m_std;

  always #5 clk = ~clk;

  pipelined_processor dut (
    .clk             (clk),
    .reset           (reset),
    .write_addr      (write_addr),
    .result          (result),
    .write_enable_fm (write_enable_fm),
    .rst_fm          (rst_fm),
    .write_data_fm   (write_data_fm),
    .write_addr_fm   (write_addr_fm),
    .instruction     (instruction),
    .mem_write       (mem_write),
    .show            (show)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  // Clear imem while a conflicting write is attempted, load the image, then release reset after E0.
  task automatic boot();
    reset = 1'b0; rst_fm = 1'b0;
    write_enable_fm = 1'b1; write_addr_fm = 32'h0000_0020; write_data_fm = 16'h0800;
    tick();
    rst_fm = 1'b1; write_enable_fm = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (img[i] != 16'h0000) begin
        write_enable_fm = 1'b1;
        write_addr_fm   = {24'($urandom), 8'(i)};
        write_data_fm   = img[i];
        tick();
      end
    end
    write_enable_fm = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Sequential instruction-set interpreter: one instruction completes per step.
  task automatic model_run(input int steps);
    logic [15:0] pc, w;
    logic [16:0] s;
    logic [2:0]  a, b;
    for (int r = 0; r < 8; r++) mr[r] = 16'(r);
    for (int i = 0; i < 256; i++) mdm[i] = 16'h0000;
    mf = 3'b000; m_std = 0; pc = 16'h0020;
    repeat (steps) begin
      w = img[pc[7:0]]; a = w[10:8]; b = w[7:5]; pc = pc + 16'd1;
      case (w[15:11])
        M_SETC: mf[2] = 1'b1;
        M_NOT: begin mr[a] = ~mr[a]; mf[1] = mr[a][15]; mf[0] = (mr[a] == 16'h0); end
        M_ADD: begin
          s = {1'b0, mr[a]} + {1'b0, mr[b]};
          mr[b] = s[15:0];
          mf = {s[16], s[15], (s[15:0] == 16'h0)};
        end
        M_STD: begin mdm[mr[b][7:0]] = mr[a]; m_std++; end
        M_LDD: mr[a] = mdm[mr[b][7:0]];
        M_JMP: pc = mr[a];
        default: ;
      endcase
    end
  endtask

  task automatic check_arch(input string tag);
    for (int r = 0; r < 8; r++) begin
      write_addr = 3'(r);
      #1;
      chk($sformatf("%s_R%0d", tag, r), result, mr[r]);
    end
    chk({tag, "_flags"}, show, {13'b0, mf});
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0] op;
    case ($urandom_range(0, 9))
      0: op = M_NOP;
      1: op = M_SETC;
      2: op = M_NOT;
      3, 4: op = M_ADD;
      5, 6: op = M_STD;
      7, 8: op = M_LDD;
      default: op = ($urandom_range(0, 1) == 0) ? 5'b11111 : 5'b00010;
    endcase
    return {op, 3'($urandom), 3'($urandom), 5'($urandom)};
  endfunction

  initial begin
    reset = 1'b0; rst_fm = 1'b1; write_enable_fm = 1'b0;
    write_addr = 3'd0; write_data_fm = 16'h0; write_addr_fm = 32'h0;

    // Empty image: reset state, and the clear must beat the simultaneous SETC write.
    clear_img();
    model_run(0);
    boot();
    chk("reset_instruction", instruction, 16'h0000);
    chk("reset_mem_write", {15'b0, mem_write}, 16'h0000);
    chk("reset_show", show, 16'h0000);
    check_arch("reset");
    repeat (8) tick();
    chk("clear_beats_write_show", show, 16'h0000);

    clear_img(); img[8'h20] = 16'h0800;
    boot();
    tick(); chk("setc_instr_E1", instruction, 16'h0800);
    tick(); chk("setc_show_E2", show, 16'h0000);
    tick(); chk("setc_show_E3", show, 16'h0004);
    repeat (3) tick(); chk("setc_show_E6", show, 16'h0004);

    clear_img(); img[8'h20] = 16'hC95F;
    model_run(1);
    chk("model_add_R2", mr[2], 16'h0003);
    write_addr = 3'd2;
    boot();
    repeat (4) tick(); chk("add_R2_E4", result, 16'h0002);
    tick(); chk("add_R2_E5", result, 16'h0003);
    chk("add_show", show, 16'h0000);

    clear_img(); img[8'h20] = 16'h1B1D;
    write_addr = 3'd3;
    boot();
    repeat (2) tick(); chk("not_show_E2", show, 16'h0000);
    tick(); chk("not_show_E3", show, 16'h0002);
    repeat (2) tick(); chk("not_R3", result, 16'hFFFC);

    begin
      int cnt;
      clear_img(); img[8'h20] = 16'h6140; img[8'h21] = 16'h2740;
      write_addr = 3'd7;
      boot();
      cnt = 0;
      repeat (3) begin tick(); if (mem_write) cnt++; end
      chk("std_mem_write_E3", {15'b0, mem_write}, 16'h0001);
      repeat (9) begin tick(); if (mem_write) cnt++; end
      chk("std_mem_write_count", 16'(cnt), 16'h0001);
      chk("ldd_R7", result, 16'h0001);
    end

    clear_img();
    img[8'h20] = 16'h9300; img[8'h21] = 16'h1F00; img[8'h22] = 16'h1F00; img[8'h03] = 16'h0800;
    write_addr = 3'd7;
    boot();
    tick(); chk("jmp_instr_E1", instruction, 16'h9300);
    tick(); chk("jmp_instr_E2", instruction, 16'h1F00);
    tick(); chk("jmp_flush_E3", instruction, 16'h0000);
    tick(); chk("jmp_target_E4", instruction, 16'h0800);
    repeat (6) tick();
    chk("jmp_R7_kept", result, 16'h0007);
    chk("jmp_target_ran", show, 16'h0004);

    clear_img(); img[8'h20] = 16'hC95F; img[8'h21] = 16'hCA3F;
    model_run(2);
    chk("model_addadd_R1", mr[1], 16'h0004);
    write_addr = 3'd1;
    boot();
    repeat (10) tick();
    chk("addadd_R1", result, FWD ? 16'h0004 : 16'h0003);

    clear_img(); img[8'h20] = 16'h6540; img[8'h21] = 16'h2440; img[8'h22] = 16'hCC20;
    write_addr = 3'd1;
    boot();
    repeat (3) tick(); chk("lu_instr_E3", instruction, 16'hCC20);
    tick(); chk("lu_instr_E4", instruction, FWD ? 16'hCC20 : 16'h0000);
    repeat (8) tick();
    chk("lu_R1", result, FWD ? 16'h0006 : 16'h0005);

    // Random programs; without forwarding each instruction is followed by 3 NOPs.
    for (int p = 0; p < 24; p++) begin
      int nw, cnt;
      clear_img();
      nw = 0;
      for (int k = 0; k < 12; k++) begin
        img[8'(32 + nw)] = rand_instr();
        nw += 1 + (FWD ? int'($urandom_range(0, 2)) : 3);
      end
      model_run(nw);
      boot();
      cnt = 0;
      repeat (2 * nw + 12) begin tick(); if (mem_write) cnt++; end
      chk($sformatf("rand%0d_std_count", p), 16'(cnt), 16'(m_std));
      check_arch($sformatf("rand%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
